// File: rtl/eth_frame_log_mux.sv
// Merges the two per-interface frame-detector log streams into one source-tagged
// log stream, round-robin at packet granularity, with a registered output stage.
module eth_frame_log_mux #(
    parameter int C_AXIS_LOG_WIDTH = 64,
    parameter int C_COUNT_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        srst,
    input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_a_tdata,
    input  logic                        s_axis_log_a_tlast,
    input  logic                        s_axis_log_a_tvalid,
    output logic                        s_axis_log_a_tready,
    input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_b_tdata,
    input  logic                        s_axis_log_b_tlast,
    input  logic                        s_axis_log_b_tvalid,
    output logic                        s_axis_log_b_tready,
    output logic [C_AXIS_LOG_WIDTH-1:0] m_axis_log_tdata,
    output logic                        m_axis_log_tdest,
    output logic                        m_axis_log_tlast,
    output logic                        m_axis_log_tvalid,
    input  logic                        m_axis_log_tready,
    output logic [C_COUNT_WIDTH-1:0]    pkt_count_a,
    output logic [C_COUNT_WIDTH-1:0]    pkt_count_b
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PASS_A = 2'd1,
        PASS_B = 2'd2
    } state_t;

    state_t                      state_reg;
    logic                        last_grant_reg;
    logic [C_AXIS_LOG_WIDTH-1:0] tdata_reg;
    logic                        tdest_reg;
    logic                        tlast_reg;
    logic                        tvalid_reg;

    logic [1:0]                  src_tvalid;
    logic [1:0]                  src_tlast;
    logic [1:0]                  src_tready;
    logic [1:0]                  src_fire;
    logic [1:0]                  src_done;
    logic                        out_free;
    logic                        load;
    logic                        load_sel;
    logic [C_AXIS_LOG_WIDTH-1:0] load_data;

    assign src_tvalid = {s_axis_log_b_tvalid, s_axis_log_a_tvalid};
    assign src_tlast  = {s_axis_log_b_tlast, s_axis_log_a_tlast};

    // The output slot can take a beat when empty or being drained this cycle.
    assign out_free = ~tvalid_reg | m_axis_log_tready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            localparam state_t GRANT_STATE = (gi == 0) ? PASS_A : PASS_B;

            logic [C_COUNT_WIDTH-1:0] cnt_reg;

            // srst gates ready so no beat is handshaken and then dropped by the reset.
            assign src_tready[gi] = ~srst & out_free & (state_reg == GRANT_STATE);
            assign src_fire[gi]   = src_tvalid[gi] & src_tready[gi];
            assign src_done[gi]   = src_fire[gi] & src_tlast[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (srst) begin
                    cnt_reg <= '0;
                end else if (src_done[gi]) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign s_axis_log_a_tready = src_tready[0];
    assign s_axis_log_b_tready = src_tready[1];
    assign pkt_count_a         = g_src[0].cnt_reg;
    assign pkt_count_b         = g_src[1].cnt_reg;

    // At most one source is granted, so the fire bits are mutually exclusive.
    assign load      = |src_fire;
    assign load_sel  = src_fire[1];
    assign load_data = load_sel ? s_axis_log_b_tdata : s_axis_log_a_tdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else if (srst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A wins when alone, or on a tie when B was served last.
                    if (src_tvalid[0] && (!src_tvalid[1] || last_grant_reg)) begin
                        state_reg <= PASS_A;
                    end else if (src_tvalid[1]) begin
                        state_reg <= PASS_B;
                    end
                end
                PASS_A: begin
                    if (src_done[0]) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= 1'b0;
                    end
                end
                PASS_B: begin
                    if (src_done[1]) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid_reg <= 1'b0;
            tdata_reg  <= '0;
            tdest_reg  <= 1'b0;
            tlast_reg  <= 1'b0;
        end else if (srst) begin
            tvalid_reg <= 1'b0;
            tdata_reg  <= '0;
            tdest_reg  <= 1'b0;
            tlast_reg  <= 1'b0;
        end else if (load) begin
            tvalid_reg <= 1'b1;
            tdata_reg  <= load_data;
            tdest_reg  <= load_sel;
            tlast_reg  <= src_tlast[load_sel];
        end else if (m_axis_log_tready) begin
            tvalid_reg <= 1'b0;
        end
    end

    assign m_axis_log_tdata  = tdata_reg;
    assign m_axis_log_tdest  = tdest_reg;
    assign m_axis_log_tlast  = tlast_reg;
    assign m_axis_log_tvalid = tvalid_reg;

endmodule

// File: tb/tb_eth_frame_log_mux.sv
// Directed bench for eth_frame_log_mux: scoreboarded output order/data, timing,
// backpressure, mid-packet resets and counter wrap (on a narrow-counter twin).
module tb_eth_frame_log_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        srst;
    logic [63:0] a_tdata;
    logic        a_tlast;
    logic        a_tvalid;
    logic        a_tready;
    logic [63:0] b_tdata;
    logic        b_tlast;
    logic        b_tvalid;
    logic        b_tready;
    logic [63:0] m_tdata;
    logic        m_tdest;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] cnt_a;
    logic [31:0] cnt_b;

    logic        w_a_tready;
    logic        w_b_tready;
    logic [63:0] w_tdata;
    logic        w_tdest;
    logic        w_tlast;
    logic        w_tvalid;
    logic [2:0]  w_cnt_a;
    logic [2:0]  w_cnt_b;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_a;
    int          exp_b;
    int          t0;
    logic [65:0] got_q[$];
    logic [65:0] exp_q[$];
    int          cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_frame_log_mux #(.C_AXIS_LOG_WIDTH(64), .C_COUNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .srst(srst),
        .s_axis_log_a_tdata(a_tdata), .s_axis_log_a_tlast(a_tlast),
        .s_axis_log_a_tvalid(a_tvalid), .s_axis_log_a_tready(a_tready),
        .s_axis_log_b_tdata(b_tdata), .s_axis_log_b_tlast(b_tlast),
        .s_axis_log_b_tvalid(b_tvalid), .s_axis_log_b_tready(b_tready),
        .m_axis_log_tdata(m_tdata), .m_axis_log_tdest(m_tdest),
        .m_axis_log_tlast(m_tlast), .m_axis_log_tvalid(m_tvalid),
        .m_axis_log_tready(m_tready),
        .pkt_count_a(cnt_a), .pkt_count_b(cnt_b)
    );

    // Same stimulus, 3-bit counters, to reach the wrap point in a few packets.
    eth_frame_log_mux #(.C_AXIS_LOG_WIDTH(64), .C_COUNT_WIDTH(3)) dut_w (
        .clk(clk), .rst(rst), .srst(srst),
        .s_axis_log_a_tdata(a_tdata), .s_axis_log_a_tlast(a_tlast),
        .s_axis_log_a_tvalid(a_tvalid), .s_axis_log_a_tready(w_a_tready),
        .s_axis_log_b_tdata(b_tdata), .s_axis_log_b_tlast(b_tlast),
        .s_axis_log_b_tvalid(b_tvalid), .s_axis_log_b_tready(w_b_tready),
        .m_axis_log_tdata(w_tdata), .m_axis_log_tdest(w_tdest),
        .m_axis_log_tlast(w_tlast), .m_axis_log_tvalid(w_tvalid),
        .m_axis_log_tready(m_tready),
        .pkt_count_a(w_cnt_a), .pkt_count_b(w_cnt_b)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            got_q.push_back({m_tdest, m_tlast, m_tdata});
            cyc_q.push_back(cyc);
            $display("beat cyc=%0d dest=%0d last=%0d data=%h", cyc, m_tdest, m_tlast, m_tdata);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit src, input logic [63:0] d, input logic l, input logic v);
        if (src) begin
            b_tdata = d; b_tlast = l; b_tvalid = v;
        end else begin
            a_tdata = d; a_tlast = l; a_tvalid = v;
        end
    endtask

    // Beats are base*1, base*2, ...; valid drops for gap_len cycles after beat gap_at.
    task automatic send(input bit src, input logic [63:0] base, input int n,
                        input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            int  t;
            bit  acc;
            drive(src, base * (i + 1), (i == n - 1), 1'b1);
            t = 0;
            forever begin
                @(negedge clk);
                acc = src ? (b_tvalid && b_tready) : (a_tvalid && a_tready);
                @(posedge clk);
                #1;
                if (acc) break;
                t++;
                if (t > 100) begin
                    chk("hs_timeout", acc, 1);
                    break;
                end
            end
            if (i == gap_at && i < n - 1) begin
                drive(src, '0, 1'b0, 1'b0);
                idle(gap_len);
            end
        end
        drive(src, '0, 1'b0, 1'b0);
    endtask

    task automatic expect_pkt(input bit src, input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({src, (i == n - 1), base * (i + 1)});
    endtask

    task automatic sb_check(input string tag);
        chk({tag, "_nbeats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_cnt_a"}, cnt_a, exp_a);
        chk({tag, "_cnt_b"}, cnt_b, exp_b);
        got_q.delete();
        exp_q.delete();
        cyc_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; srst = 1'b0; m_tready = 1'b1;
        a_tdata = '0; a_tlast = 1'b0; a_tvalid = 1'b0;
        b_tdata = '0; b_tlast = 1'b0; b_tvalid = 1'b0;
        idle(2);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_ready", {a_tready, b_tready}, 0);
        chk("rst_cnt", {cnt_a, cnt_b}, 0);
        rst = 1'b0;
        idle(2);

        // 1: single A packet, first beat two cycles after valid
        t0 = cyc;
        expect_pkt(0, 64'h11, 3);
        send(0, 64'h11, 3, -1, 0);
        idle(3);
        chk("t1_nbeats_timed", cyc_q.size(), 3);
        if (cyc_q.size() >= 3) begin
            chk("t1_lat0", cyc_q[0] - t0, 2);
            chk("t1_lat1", cyc_q[1] - t0, 3);
            chk("t1_lat2", cyc_q[2] - t0, 4);
        end
        exp_a = 1; exp_b = 0;
        sb_check("t1");

        // soft reset clears counters and restores A priority
        srst = 1'b1;
        idle(1);
        srst = 1'b0;
        chk("srst_cnt", {cnt_a, cnt_b}, 0);
        chk("srst_tvalid", m_tvalid, 0);

        // 2: simultaneous A and B, two packets each -> A,B,A,B
        expect_pkt(0, 64'h100, 2);
        expect_pkt(1, 64'h200, 2);
        expect_pkt(0, 64'h300, 2);
        expect_pkt(1, 64'h400, 2);
        fork
            begin send(0, 64'h100, 2, -1, 0); send(0, 64'h300, 2, -1, 0); end
            begin send(1, 64'h200, 2, -1, 0); send(1, 64'h400, 2, -1, 0); end
        join
        idle(3);
        exp_a = 2; exp_b = 2;
        sb_check("t2");

        // 3: downstream stall for 5 cycles while beat 2 is presented
        expect_pkt(0, 64'h1000, 4);
        fork
            send(0, 64'h1000, 4, -1, 0);
            begin
                idle(3);
                m_tready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk($sformatf("t3_hold_data%0d", k), m_tdata, 64'h2000);
                    chk($sformatf("t3_hold_valid%0d", k), m_tvalid, 1);
                    chk($sformatf("t3_hold_ready%0d", k), a_tready, 0);
                end
                idle(1);
                m_tready = 1'b1;
            end
        join
        idle(3);
        exp_a = 3;
        sb_check("t3");

        // 4: B (won on tie, A served last) with a valid gap; A must wait for B's tlast
        expect_pkt(1, 64'h2000, 4);
        expect_pkt(0, 64'h3000, 2);
        fork
            send(1, 64'h2000, 4, 1, 3);
            send(0, 64'h3000, 2, -1, 0);
        join
        idle(3);
        exp_a = 4; exp_b = 3;
        sb_check("t4");

        // 5: async reset while beat 2 is on the output; leftover beats form a new packet
        exp_q.push_back({1'b0, 1'b0, 64'h4000});
        exp_q.push_back({1'b0, 1'b0, 64'hC000});
        exp_q.push_back({1'b0, 1'b1, 64'h10000});
        expect_pkt(1, 64'h5000, 1);
        fork
            send(0, 64'h4000, 4, -1, 0);
            begin
                idle(3);
                rst = 1'b1;
                #1;
                chk("t5_tvalid", m_tvalid, 0);
                chk("t5_tdata", m_tdata, 0);
                chk("t5_ctl", {m_tdest, m_tlast}, 0);
                chk("t5_cnt", {cnt_a, cnt_b}, 0);
                chk("t5_ready", {a_tready, b_tready}, 0);
                idle(2);
                rst = 1'b0;
                send(1, 64'h5000, 1, -1, 0);
            end
        join
        idle(3);
        exp_a = 1; exp_b = 1;
        sb_check("t5");

        // 6: B counter wrap on the 3-bit twin
        for (int p = 0; p < 6; p++) begin
            expect_pkt(1, 64'h6000 + p, 1);
            send(1, 64'h6000 + p, 1, -1, 0);
        end
        idle(3);
        exp_b = 7;
        chk("t6_w_pre", w_cnt_b, 3'd7);
        sb_check("t6a");
        expect_pkt(1, 64'h7000, 1);
        send(1, 64'h7000, 1, -1, 0);
        idle(3);
        exp_b = 8;
        chk("t6_w_wrap", w_cnt_b, 3'd0);
        chk("t6_w_a", w_cnt_a, 3'd1);
        sb_check("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
